// File: rtl/tlp_length_checker_pkg.sv
// Shared constants for the Gen3+ TLP length checker: link generation codes,
// beat geometry and the bit positions of the Length field inside an STP token.
package tlp_chk_pkg;

    // Link generation codes on which checking is enabled
    localparam logic [2:0] GEN3 = 3'b011;
    localparam logic [2:0] GEN4 = 3'b100;
    localparam logic [2:0] GEN5 = 3'b101;

    // Beat geometry
    localparam int DW_BYTES      = 4;
    localparam int BEAT_BYTES    = 64;
    localparam int BEAT_DWS      = BEAT_BYTES / DW_BYTES;
    localparam int SLOT_W        = 5;
    localparam int NUM_SLOTS     = 16;
    localparam int SLOT_IDX_W    = $clog2(NUM_SLOTS);
    localparam int LEN_W         = 11;
    localparam int GOOD_W        = 5;

    // Last byte index at which an STP token still has its second byte in the beat
    localparam int STP_LAST_BYTE = BEAT_BYTES - 2;

    // STP Length field: Length[3:0] = token byte0[7:4], Length[10:4] = token byte1[6:0]
    localparam int STP_LEN_LO_LSB = 4;
    localparam int STP_LEN_LO_W   = 4;
    localparam int STP_LEN_HI_LSB = 0;
    localparam int STP_LEN_HI_W   = 7;

    // True when the link generation is one on which framing is checked
    function automatic logic is_gen3_plus(input logic [2:0] g);
        return (g == GEN3) || (g == GEN4) || (g == GEN5);
    endfunction

endpackage

// File: rtl/tlp_length_checker_stp_len_extract.sv
// Combinational decode of the 11-bit Length field carried in an STP token.
// The caller hands over only the token bits that hold the field.
module stp_len_extract
    import tlp_chk_pkg::*;
(
    input  logic [STP_LEN_LO_W-1:0] lo_nib_i,
    input  logic [STP_LEN_HI_W-1:0] hi_bits_i,
    output logic [LEN_W-1:0]        len_o
);

    assign len_o = {hi_bits_i, lo_nib_i};

endmodule

// File: rtl/tlp_length_checker.sv
// TLP length checker: tracks TLPs across 512-bit beats, compares each TLP's
// DW span against the Length field of its STP token and reports per-beat
// good/error flags with one cycle of latency alongside the forwarded beat.
module tlp_length_checker
    import tlp_chk_pkg::*;
#(
    parameter int MAX_TLP_DW = 2047,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                    pclk,
    input  logic                    reset,
    input  logic [2:0]              gen,
    input  logic [511:0]            data_in,
    input  logic                    wr,
    input  logic [63:0]             wr_valid,
    input  logic [63:0]             STP_IN,
    input  logic [63:0]             SDP_IN,
    input  logic [63:0]             END_IN,
    input  logic [79:0]             length,
    output logic [511:0]            data_out,
    output logic                    wr_out,
    output logic [63:0]             wr_valid_out,
    output logic [63:0]             STP_out,
    output logic [63:0]             SDP_out,
    output logic [63:0]             END_out,
    output logic [4:0]              tlp_good,
    output logic                    len_err,
    output logic                    frame_err,
    output logic                    slot_mismatch,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic                    in_tlp
);

    localparam logic [LEN_W-1:0]      ACC_MAX      = LEN_W'(MAX_TLP_DW);
    localparam logic [LEN_W-1:0]      ACC_ONE      = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [SLOT_IDX_W-1:0] SLOT_IDX_MAX = SLOT_IDX_W'(NUM_SLOTS - 1);
    localparam logic [ERR_CNT_W-1:0]  ERR_MAX      = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0]  ERR_ONE      = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // Saturating DW accumulator step
    function automatic logic [LEN_W-1:0] acc_inc(input logic [LEN_W-1:0] a);
        return (a >= ACC_MAX) ? a : a + ACC_ONE;
    endfunction

    // Saturating END ordinal step
    function automatic logic [SLOT_IDX_W-1:0] slot_inc(input logic [SLOT_IDX_W-1:0] k);
        return (k == SLOT_IDX_MAX) ? k : k + {{(SLOT_IDX_W-1){1'b0}}, 1'b1};
    endfunction

    // Registered state and outputs
    logic [511:0]          data_q,      data_d;
    logic                  wr_q,        wr_d;
    logic [63:0]           wr_valid_q,  wr_valid_d;
    logic [63:0]           stp_q,       stp_d;
    logic [63:0]           sdp_q,       sdp_d;
    logic [63:0]           end_q,       end_d;
    logic [GOOD_W-1:0]     tlp_good_q,  tlp_good_d;
    logic                  len_err_q,   len_err_d;
    logic                  frame_err_q, frame_err_d;
    logic                  slot_mm_q,   slot_mm_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic                  in_tlp_q,    in_tlp_d;
    logic [LEN_W-1:0]      exp_len_q,   exp_len_d;
    logic [LEN_W-1:0]      acc_dw_q,    acc_dw_d;

    // Combinational scan results
    logic                  gen_ok_s;
    logic [LEN_W-1:0]      stp_len_s [BEAT_DWS];
    logic [SLOT_W-1:0]     slot_s    [NUM_SLOTS];
    logic                  scan_in_tlp_s;
    logic [LEN_W-1:0]      scan_exp_s;
    logic [LEN_W-1:0]      scan_acc_s;
    logic [SLOT_IDX_W-1:0] scan_k_s;
    logic                  scan_open_s;
    logic [GOOD_W-1:0]     scan_good_s;
    logic                  scan_len_err_s;
    logic                  scan_frame_err_s;
    logic                  scan_slot_mm_s;

    assign gen_ok_s = is_gen3_plus(gen);

    // A legal STP can only start on a DW boundary, so decode one Length per DW
    for (genvar d = 0; d < BEAT_DWS; d++) begin : g_stp_len
        stp_len_extract u_stp_len_extract (
            .lo_nib_i  (data_in[8*DW_BYTES*d + STP_LEN_LO_LSB +: STP_LEN_LO_W]),
            .hi_bits_i (data_in[8*(DW_BYTES*d + 1) + STP_LEN_HI_LSB +: STP_LEN_HI_W]),
            .len_o     (stp_len_s[d])
        );
    end

    // Unpack the upstream per-END length slots
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        assign slot_s[k] = length[SLOT_W*k +: SLOT_W];
    end

    // Walk the beat byte 0..63 starting from the registered TLP state
    always_comb begin
        scan_in_tlp_s    = in_tlp_q;
        scan_exp_s       = exp_len_q;
        scan_acc_s       = acc_dw_q;
        scan_k_s         = {SLOT_IDX_W{1'b0}};
        scan_open_s      = 1'b0;
        scan_good_s      = {GOOD_W{1'b0}};
        scan_len_err_s   = 1'b0;
        scan_frame_err_s = 1'b0;
        scan_slot_mm_s   = 1'b0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (STP_IN[i] && END_IN[i]) begin
                // Contradictory token: close whatever is open, open nothing
                scan_frame_err_s = 1'b1;
                scan_in_tlp_s    = 1'b0;
                scan_open_s      = 1'b0;
                scan_k_s         = slot_inc(scan_k_s);
            end else begin
                // SDP is opaque, but must not appear inside a TLP
                scan_frame_err_s = scan_frame_err_s | (SDP_IN[i] & scan_in_tlp_s);

                if (STP_IN[i]) begin
                    if ((i[1:0] != 2'd0) || (i > STP_LAST_BYTE)) begin
                        scan_frame_err_s = 1'b1;
                    end else begin
                        // An STP while a TLP is open means its END went missing
                        scan_frame_err_s = scan_frame_err_s | scan_in_tlp_s;
                        scan_exp_s       = stp_len_s[i / DW_BYTES];
                        scan_acc_s       = {LEN_W{1'b0}};
                        scan_in_tlp_s    = 1'b1;
                        scan_open_s      = 1'b1;
                    end
                end else begin
                    // no token starts on this byte
                end

                if (scan_in_tlp_s && (i[1:0] == 2'd3)) begin
                    scan_acc_s = acc_inc(scan_acc_s);
                end else begin
                    // not the last byte of a DW inside a TLP
                end

                if (END_IN[i]) begin
                    if (!scan_in_tlp_s || (i[1:0] != 2'd3)) begin
                        scan_frame_err_s = 1'b1;
                    end else begin
                        if (scan_acc_s == scan_exp_s) begin
                            scan_good_s = scan_good_s + {{(GOOD_W-1){1'b0}}, 1'b1};
                        end else begin
                            scan_len_err_s = 1'b1;
                        end
                        // Upstream slot holds span+1; only trusted for TLPs wholly in this beat
                        if (scan_open_s &&
                            (({{(LEN_W-SLOT_W){1'b0}}, slot_s[scan_k_s]} - ACC_ONE) != scan_acc_s)) begin
                            scan_slot_mm_s = 1'b1;
                        end else begin
                            // slot agrees or does not apply
                        end
                    end
                    scan_in_tlp_s = 1'b0;
                    scan_open_s   = 1'b0;
                    scan_k_s      = slot_inc(scan_k_s);
                end else begin
                    // no END on this byte
                end
            end
        end
    end

    // Next-state: forward the beat, commit the scan only for valid Gen3+ beats
    always_comb begin
        data_d      = data_in;
        wr_d        = wr;
        wr_valid_d  = wr_valid;
        stp_d       = STP_IN;
        sdp_d       = SDP_IN;
        end_d       = END_IN;
        tlp_good_d  = {GOOD_W{1'b0}};
        len_err_d   = 1'b0;
        frame_err_d = 1'b0;
        slot_mm_d   = 1'b0;
        err_count_d = err_count_q;
        in_tlp_d    = in_tlp_q;
        exp_len_d   = exp_len_q;
        acc_dw_d    = acc_dw_q;
        if (!gen_ok_s) begin
            // Dropping out of Gen3+ abandons any open TLP without reporting it
            in_tlp_d = 1'b0;
        end else if (wr) begin
            tlp_good_d  = scan_good_s;
            len_err_d   = scan_len_err_s;
            frame_err_d = scan_frame_err_s;
            slot_mm_d   = scan_slot_mm_s;
            in_tlp_d    = scan_in_tlp_s;
            exp_len_d   = scan_exp_s;
            acc_dw_d    = scan_acc_s;
            if ((scan_len_err_s || scan_frame_err_s) && (err_count_q != ERR_MAX)) begin
                err_count_d = err_count_q + ERR_ONE;
            end else begin
                err_count_d = err_count_q;
            end
        end else begin
            in_tlp_d = in_tlp_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge pclk) begin
        if (reset) begin
            data_q      <= '0;
            wr_q        <= 1'b0;
            wr_valid_q  <= '0;
            stp_q       <= '0;
            sdp_q       <= '0;
            end_q       <= '0;
            tlp_good_q  <= '0;
            len_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            slot_mm_q   <= 1'b0;
            err_count_q <= '0;
            in_tlp_q    <= 1'b0;
            exp_len_q   <= '0;
            acc_dw_q    <= '0;
        end else begin
            data_q      <= data_d;
            wr_q        <= wr_d;
            wr_valid_q  <= wr_valid_d;
            stp_q       <= stp_d;
            sdp_q       <= sdp_d;
            end_q       <= end_d;
            tlp_good_q  <= tlp_good_d;
            len_err_q   <= len_err_d;
            frame_err_q <= frame_err_d;
            slot_mm_q   <= slot_mm_d;
            err_count_q <= err_count_d;
            in_tlp_q    <= in_tlp_d;
            exp_len_q   <= exp_len_d;
            acc_dw_q    <= acc_dw_d;
        end
    end

    assign data_out      = data_q;
    assign wr_out        = wr_q;
    assign wr_valid_out  = wr_valid_q;
    assign STP_out       = stp_q;
    assign SDP_out       = sdp_q;
    assign END_out       = end_q;
    assign tlp_good      = tlp_good_q;
    assign len_err       = len_err_q;
    assign frame_err     = frame_err_q;
    assign slot_mismatch = slot_mm_q;
    assign err_count     = err_count_q;
    assign in_tlp        = in_tlp_q;

endmodule

// File: tb/tb_tlp_length_checker.sv
// Directed bench for tlp_length_checker: each step drives one beat, pushes
// the expected registered response to a scoreboard and checks it one pclk later.
module tb_tlp_length_checker;

    logic          pclk = 1'b0;
    logic          reset;
    logic [2:0]    gen;
    logic [511:0]  data_in;
    logic          wr;
    logic [63:0]   wr_valid;
    logic [63:0]   STP_IN;
    logic [63:0]   SDP_IN;
    logic [63:0]   END_IN;
    logic [79:0]   length;
    logic [511:0]  data_out;
    logic          wr_out;
    logic [63:0]   wr_valid_out;
    logic [63:0]   STP_out;
    logic [63:0]   SDP_out;
    logic [63:0]   END_out;
    logic [4:0]    tlp_good;
    logic          len_err;
    logic          frame_err;
    logic          slot_mismatch;
    logic [15:0]   err_count;
    logic          in_tlp;

    always #5 pclk = ~pclk;

    tlp_length_checker #(
        .MAX_TLP_DW (2047),
        .ERR_CNT_W  (16)
    ) dut (
        .pclk          (pclk),
        .reset         (reset),
        .gen           (gen),
        .data_in       (data_in),
        .wr            (wr),
        .wr_valid      (wr_valid),
        .STP_IN        (STP_IN),
        .SDP_IN        (SDP_IN),
        .END_IN        (END_IN),
        .length        (length),
        .data_out      (data_out),
        .wr_out        (wr_out),
        .wr_valid_out  (wr_valid_out),
        .STP_out       (STP_out),
        .SDP_out       (SDP_out),
        .END_out       (END_out),
        .tlp_good      (tlp_good),
        .len_err       (len_err),
        .frame_err     (frame_err),
        .slot_mismatch (slot_mismatch),
        .err_count     (err_count),
        .in_tlp        (in_tlp)
    );

    typedef struct packed {
        logic [511:0] data;
        logic         wr;
        logic [63:0]  wv;
        logic [63:0]  stp;
        logic [63:0]  sdp;
        logic [63:0]  endm;
        logic [4:0]   good;
        logic         len_err;
        logic         frame_err;
        logic         slot_mm;
        logic [15:0]  err;
        logic         in_tlp;
    } exp_t;

    exp_t          sb_q[$];
    string         tag_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    logic [15:0]   exp_err     = 16'd0;
    logic [511:0]  beat;

    function automatic logic [511:0] rnd_beat();
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom;
        return d;
    endfunction

    // Place an STP Length field at byte b: byte b[7:4] = L[3:0], byte b+1[6:0] = L[10:4]
    function automatic logic [511:0] put_len(input logic [511:0] d, input int b, input logic [10:0] len);
        logic [511:0] r;
        r = d;
        r[8*b + 4 +: 4] = len[3:0];
        r[8*(b+1) +: 7] = len[10:4];
        return r;
    endfunction

    function automatic logic [63:0] bm(input int n);
        logic [63:0] m;
        m = 64'd0;
        m[n] = 1'b1;
        return m;
    endfunction

    function automatic logic [79:0] sl(input logic [4:0] s0, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [4:0] s3);
        return {60'd0, s3, s2, s1, s0};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic [2:0] g, input logic w,
                        input logic [63:0] stp, input logic [63:0] sdp, input logic [63:0] endm,
                        input logic [79:0] slots,
                        input logic [4:0] e_good, input logic e_len, input logic e_frame,
                        input logic e_slot, input logic e_in);
        exp_t        e;
        string       t;
        logic        active;
        logic [63:0] wv;
        wv = {$urandom, $urandom};
        @(negedge pclk);
        reset    = rst;
        gen      = g;
        wr       = w;
        data_in  = beat;
        wr_valid = wv;
        STP_IN   = stp;
        SDP_IN   = sdp;
        END_IN   = endm;
        length   = slots;
        active   = !rst && w && ((g == 3'b011) || (g == 3'b100) || (g == 3'b101));
        if (rst) begin
            e       = '0;
            exp_err = 16'd0;
        end else begin
            e.data      = beat;
            e.wr        = w;
            e.wv        = wv;
            e.stp       = stp;
            e.sdp       = sdp;
            e.endm      = endm;
            e.good      = active ? e_good : 5'd0;
            e.len_err   = active ? e_len : 1'b0;
            e.frame_err = active ? e_frame : 1'b0;
            e.slot_mm   = active ? e_slot : 1'b0;
            if (active && (e_len || e_frame) && (exp_err != 16'hFFFF)) exp_err = exp_err + 16'd1;
            e.err       = exp_err;
            e.in_tlp    = e_in;
        end
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge pclk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".data_out"},      data_out,      e.data);
        chk({t, ".wr_out"},        wr_out,        e.wr);
        chk({t, ".wr_valid_out"},  wr_valid_out,  e.wv);
        chk({t, ".STP_out"},       STP_out,       e.stp);
        chk({t, ".SDP_out"},       SDP_out,       e.sdp);
        chk({t, ".END_out"},       END_out,       e.endm);
        chk({t, ".tlp_good"},      tlp_good,      e.good);
        chk({t, ".len_err"},       len_err,       e.len_err);
        chk({t, ".frame_err"},     frame_err,     e.frame_err);
        chk({t, ".slot_mismatch"}, slot_mismatch, e.slot_mm);
        chk({t, ".err_count"},     err_count,     e.err);
        chk({t, ".in_tlp"},        in_tlp,        e.in_tlp);
    endtask

    initial begin
        reset    = 1'b1;
        gen      = 3'd0;
        wr       = 1'b0;
        data_in  = '0;
        wr_valid = '0;
        STP_IN   = '0;
        SDP_IN   = '0;
        END_IN   = '0;
        length   = '0;
        repeat (2) @(posedge pclk);

        // Reset wins over a framed, valid beat
        beat = put_len(rnd_beat(), 0, 11'd4);
        step("reset", 1'b1, 3'd3, 1'b1, bm(0), 64'd0, bm(15), sl(5'd5, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Contained TLP, Length 4, bytes 0..15
        beat = put_len(rnd_beat(), 0, 11'd4);
        step("contained", 1'b0, 3'd3, 1'b1, bm(0), 64'd0, bm(15), sl(5'd5, 5'd0, 5'd0, 5'd0), 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Same TLP with a wrong upstream slot: informational only
        beat = put_len(rnd_beat(), 0, 11'd4);
        step("slot_bad", 1'b0, 3'd3, 1'b1, bm(0), 64'd0, bm(15), sl(5'd7, 5'd0, 5'd0, 5'd0), 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Spanning TLP: 4 DW in beat 1, 16 DW in beat 2; slot ignored on beat 2
        beat = put_len(rnd_beat(), 48, 11'd20);
        step("span1", 1'b0, 3'd4, 1'b1, bm(48), 64'd0, 64'd0, sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        beat = rnd_beat();
        step("span2", 1'b0, 3'd4, 1'b1, 64'd0, 64'd0, bm(63), sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Length mismatch: field says 6, span is 4
        beat = put_len(rnd_beat(), 0, 11'd6);
        step("len_mm", 1'b0, 3'd3, 1'b1, bm(0), 64'd0, bm(15), sl(5'd5, 5'd0, 5'd0, 5'd0), 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Orphan END, then misaligned STP
        beat = rnd_beat();
        step("orphan", 1'b0, 3'd3, 1'b1, 64'd0, 64'd0, bm(7), sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        beat = put_len(rnd_beat(), 2, 11'd4);
        step("stp_misal", 1'b0, 3'd3, 1'b1, bm(2), 64'd0, 64'd0, sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a TLP, then its END is an orphan
        beat = put_len(rnd_beat(), 0, 11'd40);
        step("rst_open", 1'b0, 3'd3, 1'b1, bm(0), 64'd0, 64'd0, sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        beat = rnd_beat();
        step("rst_mid", 1'b1, 3'd3, 1'b1, 64'd0, 64'd0, bm(31), sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat = rnd_beat();
        step("rst_end", 1'b0, 3'd3, 1'b1, 64'd0, 64'd0, bm(31), sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Gen2: same framing as the mismatch case, nothing is checked
        beat = put_len(rnd_beat(), 0, 11'd6);
        step("gen2", 1'b0, 3'd2, 1'b1, bm(0), 64'd0, bm(15), sl(5'd5, 5'd0, 5'd0, 5'd0), 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Leaving Gen3+ with a TLP open drops it silently
        beat = put_len(rnd_beat(), 60, 11'd1);
        step("gen_open", 1'b0, 3'd5, 1'b1, bm(60), 64'd0, 64'd0, sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        beat = rnd_beat();
        step("gen_drop", 1'b0, 3'd2, 1'b1, 64'd0, 64'd0, 64'd0, sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat = rnd_beat();
        step("gen_back", 1'b0, 3'd3, 1'b1, 64'd0, 64'd0, bm(3), sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Four TLPs in one beat (2,1,3,5 DW) using slots 0..3
        beat = put_len(put_len(put_len(put_len(rnd_beat(), 0, 11'd2), 8, 11'd1), 16, 11'd3), 32, 11'd5);
        step("multi", 1'b0, 3'd3, 1'b1, bm(0) | bm(8) | bm(16) | bm(32), 64'd0,
             bm(7) | bm(11) | bm(27) | bm(51), sl(5'd3, 5'd2, 5'd4, 5'd6), 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        beat = put_len(put_len(put_len(put_len(rnd_beat(), 0, 11'd2), 8, 11'd1), 16, 11'd3), 32, 11'd5);
        step("multi_k", 1'b0, 3'd3, 1'b1, bm(0) | bm(8) | bm(16) | bm(32), 64'd0,
             bm(7) | bm(11) | bm(27) | bm(51), sl(5'd3, 5'd2, 5'd4, 5'd7), 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);

        // STP while open: missing END flagged, new TLP (1 DW) still checks good
        beat = put_len(put_len(rnd_beat(), 0, 11'd1), 4, 11'd1);
        step("stp_open", 1'b0, 3'd3, 1'b1, bm(0) | bm(4), 64'd0, bm(7), sl(5'd2, 5'd0, 5'd0, 5'd0), 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);

        // STP and END on the same byte close the open TLP, nothing reopens
        beat = put_len(rnd_beat(), 0, 11'd2);
        step("stp_end", 1'b0, 3'd3, 1'b1, bm(0) | bm(4), 64'd0, bm(4), sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // SDP inside a TLP
        beat = put_len(rnd_beat(), 0, 11'd4);
        step("sdp_in", 1'b0, 3'd3, 1'b1, bm(0), bm(8), bm(15), sl(5'd5, 5'd0, 5'd0, 5'd0), 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);

        // wr=0 holds state; framing on the idle beat is ignored
        beat = put_len(rnd_beat(), 48, 11'd8);
        step("hold_open", 1'b0, 3'd3, 1'b1, bm(48), 64'd0, 64'd0, sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        beat = rnd_beat();
        step("hold_idle", 1'b0, 3'd3, 1'b0, bm(0), 64'd0, bm(3), sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        beat = rnd_beat();
        step("hold_end", 1'b0, 3'd3, 1'b1, 64'd0, 64'd0, bm(15), sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Misaligned END with a TLP open
        beat = put_len(rnd_beat(), 0, 11'd2);
        step("end_misal", 1'b0, 3'd3, 1'b1, bm(0), 64'd0, bm(6), sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Accumulator clamps at 2047: 16 + 127*16 DW would be 2048
        beat = put_len(rnd_beat(), 0, 11'd2047);
        step("sat_open", 1'b0, 3'd3, 1'b1, bm(0), 64'd0, 64'd0, sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 127; n++) begin
            beat = rnd_beat();
            step("sat_body", 1'b0, 3'd3, 1'b1, 64'd0, 64'd0, 64'd0, sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        beat = rnd_beat();
        step("sat_end", 1'b0, 3'd3, 1'b1, 64'd0, 64'd0, bm(3), sl(5'd0, 5'd0, 5'd0, 5'd0), 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlp_length_checker.md
Name: tlp_length_checker

Overview:
- Stage directly downstream of the per-beat DW length counter in the Gen3+ receive MAC path.
- Consumes the 512-bit beat, the STP/SDP/END byte masks and the 16 packed 5-bit per-TLP lengths.
- Tracks TLPs across beats and checks each TLP's actual DW span against the 11-bit Length field in its STP token.
- Forwards the beat with one cycle of latency, plus per-beat good/error flags and a saturating error counter.

Parameters:
MAX_TLP_DW, 2047, ceiling for the accumulated DW count; the accumulator clamps here.
ERR_CNT_W, 16, width of the saturating error counter.

Ports:
pclk  input  1  clock
reset  input  1  synchronous, active-high reset
gen  input  3  link generation; checking is enabled only for 3'b011, 3'b100 and 3'b101
data_in  input  512  beat data; byte i is data_in[8i+7:8i]
wr  input  1  beat valid
wr_valid  input  64  per-byte valid
STP_IN  input  64  per-byte STP token start mask
SDP_IN  input  64  per-byte SDP mask
END_IN  input  64  per-byte TLP last-byte mask
length  input  80  16 x 5-bit slots; slot k is bits [5k+4:5k] and belongs to the k-th END in the beat; value = inclusive DW span + 1
data_out  output  512  registered data_in
wr_out  output  1  registered wr
wr_valid_out  output  64  registered wr_valid
STP_out  output  64  registered STP_IN
SDP_out  output  64  registered SDP_IN
END_out  output  64  registered END_IN
tlp_good  output  5  number of TLPs that closed correctly in this beat
len_err  output  1  at least one Length-field mismatch in this beat
frame_err  output  1  at least one framing violation in this beat
slot_mismatch  output  1  an in-beat TLP whose upstream slot disagrees with the internal count
err_count  output  ERR_CNT_W  saturating count of beats with len_err or frame_err
in_tlp  output  1  a TLP is open at the end of the last processed beat

Behaviour:
- Reset: every output is 0, and the internal in_tlp, exp_len (11 bits), acc_dw (11 bits) and slot index are 0. Reset wins over wr in the same cycle.
- Latency: every output is registered and reflects the beat presented one pclk earlier. The pass-through fields are registered every cycle, independent of wr.
- When wr=0 or gen is not Gen3+: flags are 0 and internal state holds.
- When gen leaves Gen3+ while in_tlp=1: in_tlp is cleared silently, with no error.
- Scan: the beat is scanned combinationally from byte 0 to byte 63. The registered state is the starting point.
- STP at byte b:
  - b%4 != 0, or b > 62: frame_err, and the token is ignored.
  - in_tlp already 1: frame_err (missing END), and the new TLP opens anyway.
  - Otherwise: exp_len = {byte(b+1)[6:0], byte(b)[7:4]}, acc starts at 0, in_tlp=1.
- Accumulate: while in_tlp, acc_dw increments on each byte index where i%4==3. It saturates at MAX_TLP_DW.
- END at byte e:
  - in_tlp=0: frame_err (orphan END).
  - e%4 != 3: frame_err.
  - Otherwise compare acc_dw with exp_len. Equal: tlp_good increments. Different: len_err.
  - In all END cases the TLP closes (in_tlp=0), and the END ordinal k increments, saturating at 15.
- Slot check: applies only when the TLP opened in the same beat. If length slot k minus 1 differs from acc_dw, slot_mismatch is set; this is informational and not counted in err_count.
- STP and END on the same byte: frame_err; any open TLP is closed; no new TLP opens.
- SDP: treated as opaque. SDP while in_tlp is a frame_err.
- err_count: increments by 1 per beat with len_err or frame_err. It holds at all-ones.
- A TLP open across beats carries in_tlp, exp_len and acc_dw in registers.

Decomposition:
- Shared package tlp_chk_pkg holds:
  - GEN3/GEN4/GEN5 codes
  - STP length bit positions
  - DW_BYTES=4, BEAT_BYTES=64, SLOT_W=5, NUM_SLOTS=16, LEN_W=11
- One sub-module, stp_len_extract: a combinational 11-bit Length decode from two token bytes.

Test Plan:
- Contained TLP:
  - Stimulus: gen=3, STP byte0 with Length=4, END byte15, slot0=5.
  - Response, next cycle: tlp_good=1, len_err=0, slot_mismatch=0, in_tlp=0.
- Spanning TLP:
  - Stimulus: STP byte48 with Length=20; next beat END byte63.
  - Response: beat1 flags 0 and in_tlp=1; beat2 tlp_good=1 and in_tlp=0.
- Length mismatch:
  - Stimulus: STP byte0 with Length=6, END byte15.
  - Response: len_err=1, tlp_good=0, err_count=1.
- Orphan and misaligned:
  - Stimulus: END byte7 with no open TLP; then STP at byte2.
  - Response: frame_err=1 on each beat, err_count=2.
- Reset mid-TLP:
  - Stimulus: STP byte0 with Length=40, assert reset for one cycle, then END byte31.
  - Response: outputs 0 during reset; the END beat gives frame_err=1.
- Gen gating:
  - Stimulus: gen=2 with the same framing as the mismatch case.
  - Response: pass-through fields registered; all flags 0; err_count unchanged.
